// File: rtl/rle_pkg.sv
// Shared constants and types for the zero-run RLE encoder/decoder pair.
package rle_pkg;

  localparam int DATA_W    = 8;
  localparam int RUN_W     = 6;
  localparam int BLOCK_LEN = 64;
  localparam int POS_W     = $clog2(BLOCK_LEN);

  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(BLOCK_LEN - 1);
  localparam logic [RUN_W:0]   RUN_LIMIT = (RUN_W + 1)'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ZEROS = 2'd1,
    DATA  = 2'd2,
    FILL  = 2'd3
  } dec_state_e;

  typedef struct packed {
    logic              eob;
    logic [RUN_W-1:0]  run;
    logic [DATA_W-1:0] data;
  } rle_sym_t;

  // Zeros still owed after the first EOB zero lands at position pos.
  function automatic logic [RUN_W-1:0] fill_count(input logic [POS_W-1:0] pos);
    return RUN_W'(POS_LAST - pos);
  endfunction

endpackage

// File: rtl/rle_coef_out_reg.sv
// Registered coefficient output stage with valid/ready hold and the advance term.
module rle_coef_out_reg
  import rle_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              coef_ready,
  output logic              adv,
  output logic              coef_valid,
  output logic [DATA_W-1:0] coef_data,
  output logic              coef_last
);

  assign adv = !coef_valid || coef_ready;

  // Output register: refilled on adv, otherwise held for the stalled consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_valid <= 1'b0;
      coef_data  <= {DATA_W{1'b0}};
      coef_last  <= 1'b0;
    end else if (adv) begin
      coef_valid <= load;
      if (load) begin
        coef_data <= load_data;
        coef_last <= load_last;
      end else begin
        coef_last <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rle_zero_decoder.sv
// Expands (zero-run, value) symbols into a flat 64-coefficient block stream.
// Optional statistics counters are enabled with the RLE_DEC_STATS_EN macro.
module rle_zero_decoder
  import rle_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic [RUN_W-1:0]  sym_run,
  input  logic [DATA_W-1:0] sym_data,
  input  logic              sym_eob,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [DATA_W-1:0] coef_data,
  output logic              coef_last,
  output logic              err
`ifdef RLE_DEC_STATS_EN
  ,
  output logic [15:0]       blk_cnt,
  output logic [7:0]        err_cnt
`endif
);

  dec_state_e        state_r;
  logic [POS_W-1:0]  pos_r;
  logic [RUN_W-1:0]  run_cnt_r;
  logic [DATA_W-1:0] hold_data_r;
  logic              err_r;

  rle_sym_t          sym_s;
  logic              adv_s;
  logic              accept_s;
  logic              overflow_s;
  logic              load_s;
  logic              load_last_s;
  logic [DATA_W-1:0] load_data_s;
  logic [RUN_W:0]    run_end_s;

  assign sym_s       = {sym_eob, sym_run, sym_data};
  assign sym_ready   = (state_r == IDLE) && adv_s;
  assign accept_s    = sym_valid && sym_ready;
  assign run_end_s   = (RUN_W + 1)'(pos_r) + (RUN_W + 1)'(sym_s.run);
  assign overflow_s  = (run_end_s > RUN_LIMIT);
  assign load_last_s = (pos_r == POS_LAST);
  assign err         = err_r;

  // Choose what the output stage loads this cycle; load only ever rises with adv.
  always_comb begin
    load_s      = 1'b0;
    load_data_s = {DATA_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (accept_s && (sym_s.eob || !overflow_s)) begin
          load_s = 1'b1;
          if (!sym_s.eob && (sym_s.run == {RUN_W{1'b0}})) begin
            load_data_s = sym_s.data;
          end else begin
            load_data_s = {DATA_W{1'b0}};
          end
        end else begin
          load_s = 1'b0;
        end
      end
      ZEROS:   load_s = adv_s;
      FILL:    load_s = adv_s;
      DATA: begin
        load_s      = adv_s;
        load_data_s = hold_data_r;
      end
      default: load_s = 1'b0;
    endcase
  end

  // Decoder FSM, block position and run counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pos_r       <= {POS_W{1'b0}};
      run_cnt_r   <= {RUN_W{1'b0}};
      hold_data_r <= {DATA_W{1'b0}};
      err_r       <= 1'b0;
    end else begin
      err_r <= accept_s && !sym_s.eob && overflow_s;
      if (load_s) begin
        pos_r <= load_last_s ? {POS_W{1'b0}} : pos_r + POS_W'(1);
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (sym_s.eob) begin
              run_cnt_r <= fill_count(pos_r);
              state_r   <= load_last_s ? IDLE : FILL;
            end else if (!overflow_s && (sym_s.run != {RUN_W{1'b0}})) begin
              hold_data_r <= sym_s.data;
              run_cnt_r   <= sym_s.run - RUN_W'(1);
              state_r     <= (sym_s.run > RUN_W'(1)) ? ZEROS : DATA;
            end
          end
        end
        ZEROS: begin
          if (adv_s) begin
            run_cnt_r <= run_cnt_r - RUN_W'(1);
            if (run_cnt_r == RUN_W'(1)) state_r <= DATA;
          end
        end
        DATA: begin
          if (adv_s) state_r <= IDLE;
        end
        FILL: begin
          if (adv_s) begin
            run_cnt_r <= run_cnt_r - RUN_W'(1);
            if (run_cnt_r == RUN_W'(1)) state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  rle_coef_out_reg u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_s),
    .load_data  (load_data_s),
    .load_last  (load_last_s),
    .coef_ready (coef_ready),
    .adv        (adv_s),
    .coef_valid (coef_valid),
    .coef_data  (coef_data),
    .coef_last  (coef_last)
  );

`ifdef RLE_DEC_STATS_EN
  logic [15:0] blk_cnt_r;
  logic [7:0]  err_cnt_r;

  // Completed-block and saturating overflow-error counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt_r <= 16'd0;
      err_cnt_r <= 8'd0;
    end else begin
      if (coef_valid && coef_ready && coef_last) blk_cnt_r <= blk_cnt_r + 16'd1;
      if (err_r && (err_cnt_r != 8'hFF)) err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  assign blk_cnt = blk_cnt_r;
  assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_rle_zero_decoder.sv
// Directed bench for rle_zero_decoder with a queue-based block expansion model.
module tb_rle_zero_decoder;
  import rle_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sym_valid, sym_ready, sym_eob;
  logic [RUN_W-1:0]  sym_run;
  logic [DATA_W-1:0] sym_data;
  logic              coef_valid, coef_ready, coef_last, err;
  logic [DATA_W-1:0] coef_data;
`ifdef RLE_DEC_STATS_EN
  logic [15:0]       blk_cnt;
  logic [7:0]        err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int mpos  = 0;
  int cyc   = 0;
  logic        err_next = 1'b0;
  logic        stall_prev = 1'b0;
  logic [8:0]  stall_val;
  logic [9:0]  exp_q[$];
  logic [8:0]  got_log[$];
  int          hs_q[$];

  rle_zero_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_run(sym_run),
    .sym_data(sym_data), .sym_eob(sym_eob),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .coef_last(coef_last), .err(err)
`ifdef RLE_DEC_STATS_EN
    , .blk_cnt(blk_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_coef(input logic [7:0] d);
    exp_q.push_back({1'b1, d, (mpos == BLOCK_LEN - 1)});
    mpos = (mpos + 1) % BLOCK_LEN;
  endtask

  // Block-level meaning of one accepted symbol.
  task automatic model_sym(input logic eob, input int r, input logic [7:0] d);
    if (eob) begin
      do push_coef(8'h00); while (mpos != 0);
    end else if (mpos + r > BLOCK_LEN - 1) begin
      err_next = 1'b1;
    end else begin
      repeat (r) push_coef(8'h00);
      push_coef(d);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        mpos = 0;
        err_next = 1'b0;
        stall_prev = 1'b0;
      end else begin
        chk("err", err, err_next);
        err_next = 1'b0;
        if (stall_prev) begin
          chk("stall_valid", coef_valid, 1);
          chk("stall_hold", {coef_data, coef_last}, stall_val);
        end
        if (sym_valid && sym_ready) model_sym(sym_eob, int'(sym_run), sym_data);
        if (coef_valid && coef_ready) begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h000;
          chk("coef", {1'b1, coef_data, coef_last}, e);
          got_log.push_back({coef_data, coef_last});
          hs_q.push_back(cyc);
        end
        stall_prev = coef_valid && !coef_ready;
        if (stall_prev) begin
          stall_val = {coef_data, coef_last};
          chk("sym_ready_stall", sym_ready, 0);
        end
      end
    end
  end

  task automatic send(input logic eob, input int r, input logic [7:0] d);
    logic done;
    done = 1'b0;
    sym_valid = 1'b1; sym_eob = eob; sym_run = RUN_W'(r); sym_data = d;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      done = sym_ready;
      @(posedge clk); #1;
    end
    sym_valid = 1'b0;
    chk("sym_accept", done, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic clear_logs();
    got_log.delete();
    hs_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sym_valid = 1'b0; sym_eob = 1'b0; sym_run = '0; sym_data = '0;
    coef_ready = 1'b1;
    #12;
    chk("rst_valid", coef_valid, 0);
    chk("rst_data", coef_data, 0);
    chk("rst_last", coef_last, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single run=3 symbol: first coefficient visible the cycle after acceptance.
    clear_logs();
    send(1'b0, 3, 8'h5A);
    chk("t1_lat_valid", coef_valid, 1);
    chk("t1_lat_data", coef_data, 0);
    drain();
    chk("t1_count", got_log.size(), 4);
    chk("t1_first", got_log[0], {8'h00, 1'b0});
    chk("t1_value", got_log[3], {8'h5A, 1'b0});
    chk("t1_pos", mpos, 4);

    // Close the block from pos 4, then 64 back-to-back literal symbols.
    clear_logs();
    send(1'b1, 0, 8'h00);
    drain();
    chk("eob60_count", got_log.size(), 60);
    chk("eob60_last", got_log[59], {8'h00, 1'b1});
    clear_logs();
    for (int i = 0; i < 64; i++) send(1'b0, 0, 8'(i + 1));
    drain();
    chk("t2_count", got_log.size(), 64);
    chk("t2_first", got_log[0], {8'h01, 1'b0});
    chk("t2_pen", got_log[62], {8'h3F, 1'b0});
    chk("t2_last", got_log[63], {8'h40, 1'b1});
    chk("t2_nobubble", hs_q[63] - hs_q[0], 63);
    chk("t2_pos", mpos, 0);

    // run=2, run=7, then EOB fills 53 zeros.
    clear_logs();
    send(1'b0, 2, 8'h11);
    send(1'b0, 7, 8'h22);
    chk("t3_pos", mpos, 11);
    send(1'b1, 0, 8'hEE);
    drain();
    chk("t3_count", got_log.size(), 64);
    chk("t3_d1", got_log[2], {8'h11, 1'b0});
    chk("t3_d2", got_log[10], {8'h22, 1'b0});
    chk("t3_fill_last", got_log[63], {8'h00, 1'b1});

    // Downstream stall in the middle of a zero run.
    clear_logs();
    send(1'b0, 5, 8'h66);
    @(posedge clk); #1 coef_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 coef_ready = 1'b1;
    drain();
    chk("t4_count", got_log.size(), 6);
    chk("t4_value", got_log[5], {8'h66, 1'b0});
    chk("t4_zero", got_log[4], {8'h00, 1'b0});

    // Overflow at pos 60, then an exactly fitting run ending the block.
    clear_logs();
    send(1'b0, 53, 8'h09);
    chk("t5_pos", mpos, 60);
    send(1'b0, 5, 8'h77);
    chk("t5_err_pulse", err, 1);
    chk("t5_no_coef", coef_valid, 0);
    @(posedge clk); #1;
    chk("t5_err_clear", err, 0);
    send(1'b0, 3, 8'h07);
    drain();
    chk("t5_count", got_log.size(), 58);
    chk("t5_tail", got_log[57], {8'h07, 1'b1});
    chk("t5_pre", got_log[56], {8'h00, 1'b0});

    // Asynchronous reset in the middle of an EOB fill.
    clear_logs();
    send(1'b1, 0, 8'h00);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", coef_valid, 0);
    chk("t6_rst_last", coef_last, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    send(1'b0, 0, 8'h33);
    drain();
    chk("t6_count", got_log.size(), 1);
    chk("t6_value", got_log[0], {8'h33, 1'b0});
    send(1'b1, 0, 8'h00);
    drain();
    chk("t6_block", got_log.size(), 64);
    chk("t6_block_last", got_log[63], {8'h00, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rle_zero_decoder.md
Name: rle_zero_decoder

Overview:
- Inverse of the zero-run packer: consumes (zero-run, value) symbols and expands them back into a flat stream of 8-bit coefficients, one per cycle.
- Symbols can carry an end-of-block flag; the block fills the rest of the 64-coefficient block with zeros.
- Sits between the entropy-decode front end and the dequantiser/IDCT input buffer.
- Valid/ready handshake on both sides; registered output.

Parameters:
- DATA_W, 8, coefficient/value width.
- RUN_W, 6, zero-run field width (0..63).
- BLOCK_LEN, 64, coefficients per block.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sym_valid  in  1  input symbol valid.
- sym_ready  out  1  symbol accepted when sym_valid && sym_ready.
- sym_run  in  RUN_W  zeros preceding the value.
- sym_data  in  DATA_W  value following the zeros.
- sym_eob  in  1  end of block; sym_run/sym_data are ignored.
- coef_valid  out  1  output coefficient valid.
- coef_ready  in  1  downstream ready.
- coef_data  out  DATA_W  output coefficient.
- coef_last  out  1  high with the final coefficient of a block (position BLOCK_LEN-1).
- err  out  1  one-cycle pulse when a symbol overflows the block.

Behaviour:
- Reset (async, rst_n low): coef_valid=0, coef_data=0, coef_last=0, err=0, state=IDLE, pos=0, run_cnt=0. Reset mid-operation discards the partial block and any held symbol.
- Define adv = !coef_valid || coef_ready. The output register loads only when adv=1; otherwise coef_data/coef_last are held stable.
- sym_ready = (state==IDLE) && adv. It is purely combinational from state and adv.
- Each loaded coefficient does three things:
  - pos increments.
  - coef_last = (pos==BLOCK_LEN-1).
  - pos wraps to 0 after BLOCK_LEN-1.
- States:
  - IDLE
    - Accepting a non-EOB symbol with R=sym_run, D=sym_data:
      - If pos+R > BLOCK_LEN-1: err=1 for one cycle, symbol consumed and dropped, nothing loaded, stay IDLE.
      - Else if R==0: load D, stay IDLE.
      - Else: load 0, latch D, run_cnt=R-1, go ZEROS if R>1 else DATA.
    - Accepting an EOB symbol: load 0, run_cnt=BLOCK_LEN-1-pos, go FILL; if run_cnt==0 stay IDLE.
  - ZEROS: on adv, load 0 and decrement run_cnt; when run_cnt reaches 0, go DATA.
  - DATA: on adv, load the latched D, go IDLE.
  - FILL: on adv, load 0 and decrement run_cnt; at 0, go IDLE. The final load always carries coef_last=1 and pos returns to 0.
- Latency: a symbol accepted at cycle N has its first coefficient valid at N+1.
- Throughput: one coefficient per adv cycle. There are no bubbles between symbols, because the next symbol is accepted in the cycle after DATA or an R==0 load.
- A value of D=0 in a non-EOB symbol is legal and emitted as-is.
- An EOB symbol at pos==0 emits a full block of BLOCK_LEN zeros.
- Width rules:
  - The overflow compare uses RUN_W+1 bits.
  - pos is clog2(BLOCK_LEN) bits.
  - run_cnt is RUN_W bits.

Optional Feature:
- Macro: RLE_DEC_STATS_EN.
- When defined, two extra output ports exist:
  - blk_cnt [15:0]: increments on every coef_last handshake.
  - err_cnt [7:0]: increments on every err pulse and saturates at 255.
  - Both reset to 0.
- When undefined, these ports and counters are absent and the core behaviour is identical.

Decomposition:
- Package rle_pkg holds:
  - DATA_W, RUN_W, BLOCK_LEN constants.
  - State enum {IDLE, ZEROS, DATA, FILL}.
  - Symbol struct {eob, run, data}, shared with the encoder side.
- One natural sub-module: rle_coef_out_reg. It holds the output valid/data/last register and the adv logic. The decoder FSM and counters stay in the top.

Test Plan:
- Single symbol run=3, data=0x5A, coef_ready=1, accepted at cycle N -> coefs 0,0,0,0x5A at N+1..N+4; pos=4; coef_last=0.
- 64 back-to-back run=0 symbols with data 0x01..0x40 -> 64 consecutive coefs with no bubble; coef_last only with 0x40; pos=0 afterwards.
- run=2 data=0x11, then run=7 data=0x22 (pos=11), then EOB -> 53 zeros; coef_last on the final zero; next symbol starts a new block at pos=0.
- coef_ready held low 3 cycles mid-ZEROS (run=5) -> coef_data/coef_valid stable, sym_ready=0, no coefficient lost or duplicated; total 6 coefs.
- pos=60, symbol run=5 -> err pulse one cycle, symbol consumed, no coefs; then run=3 data=0x07 -> 0,0,0,0x07 with coef_last on 0x07.
- Assert rst_n low asynchronously mid-FILL -> coef_valid=0, coef_last=0, pos=0 immediately; after release, run=0 data=0x33 emits 0x33 at pos 0.
